// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
//
// Host-to-FPGA command receiver for the oscilloscope. A 2-flop synchroniser
// feeds an 8N1 byte receiver, whose bytes feed a packet parser that looks for
// 5-byte packets: 0xA5, command, argument low, argument high, checksum
// (cmd ^ arg_lo ^ arg_hi). Accepted packets are shown as a one-cycle strobe
// with held code/argument registers. Framing, checksum and inter-byte
// timeout errors each strobe for one cycle and are tallied in a saturating
// 8-bit counter.
//
// Parameters:
//   DELAY_FRAMES  - clock cycles per UART bit
//   FRAME_TIMEOUT - idle cycles allowed between bytes of one packet
//
// Ports:
//   i_clk             - system clock, rising edge
//   i_rst_n           - asynchronous active-low reset
//   i_uart_rx         - serial line, idle high, asynchronous to i_clk
//   o_rx_byte         - last correctly framed byte
//   o_rx_byte_valid   - one-cycle strobe when o_rx_byte updates
//   o_cmd_valid       - one-cycle strobe for an accepted packet
//   o_cmd_code        - command byte of the last accepted packet (held)
//   o_cmd_arg         - 16-bit argument of the last accepted packet (held)
//   o_frame_error     - one-cycle strobe when a stop bit is sampled low
//   o_csum_error      - one-cycle strobe on checksum mismatch
//   o_timeout_error   - one-cycle strobe when the inter-byte timeout expires
//   o_err_count       - saturating count of cycles with any error strobe
// ---------------------------------------------------------------------------
module uart_cmd_rx #(
  parameter int DELAY_FRAMES  = 234,
  parameter int FRAME_TIMEOUT = 2_700_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_uart_rx,
  output logic [7:0]  o_rx_byte,
  output logic        o_rx_byte_valid,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_code,
  output logic [15:0] o_cmd_arg,
  output logic        o_frame_error,
  output logic        o_csum_error,
  output logic        o_timeout_error,
  output logic [7:0]  o_err_count
);

  localparam int CNT_W = $clog2(DELAY_FRAMES);
  localparam int TMO_W = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] HALF      = CNT_W'(DELAY_FRAMES / 2);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(FRAME_TIMEOUT);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_BREAK
  } byte_state_t;

  typedef enum logic [2:0] {
    P_SYNC,
    P_CMD,
    P_ARG_LO,
    P_ARG_HI,
    P_CSUM
  } pkt_state_t;

  // ------------------------------------------------------------------
  // Synchroniser
  // ------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic w_rx;

  // Flops reset high so a reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx = r_rx_sync;

  // ------------------------------------------------------------------
  // Byte receiver
  // ------------------------------------------------------------------
  byte_state_t      r_bstate;
  byte_state_t      w_bstate_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_byte;
  logic             r_rx_byte_valid;
  logic             r_frame_error;
  logic             w_half_tick;
  logic             w_bit_tick;
  logic             w_data_shift;
  logic             w_byte_done;
  logic             w_frame_set;

  // In START the counter holds the cycle number since the falling edge was
  // seen, so the half-bit tick lands at cycle HALF. In DATA/STOP it restarts
  // at 0 after each sample, so every later sample is a full bit apart.
  assign w_half_tick = (r_bit_cnt == HALF);
  assign w_bit_tick  = (r_bit_cnt == BIT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bstate <= B_IDLE;
    end else begin
      r_bstate <= w_bstate_next;
    end
  end

  always_comb begin
    w_bstate_next = r_bstate;
    w_data_shift  = 1'b0;
    w_byte_done   = 1'b0;
    w_frame_set   = 1'b0;
    case (r_bstate)
      B_IDLE: begin
        if (!w_rx) begin
          w_bstate_next = B_START;
        end
      end
      B_START: begin
        if (w_half_tick) begin
          w_bstate_next = w_rx ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (w_bit_tick) begin
          w_data_shift = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_bstate_next = B_STOP;
          end
        end
      end
      B_STOP: begin
        if (w_bit_tick) begin
          if (w_rx) begin
            w_byte_done   = 1'b1;
            w_bstate_next = B_IDLE;
          end else begin
            w_frame_set   = 1'b1;
            w_bstate_next = B_BREAK;
          end
        end
      end
      B_BREAK: begin
        if (w_rx) begin
          w_bstate_next = B_IDLE;
        end
      end
      default: begin
        w_bstate_next = B_IDLE;
      end
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register.
  // IDLE preloads 1 because the cycle that leaves IDLE is cycle 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_bstate)
        B_IDLE: begin
          r_bit_cnt <= CNT_W'(1);
          r_bit_idx <= '0;
        end
        B_START: begin
          r_bit_cnt <= w_half_tick ? '0 : r_bit_cnt + CNT_W'(1);
        end
        B_DATA: begin
          r_bit_cnt <= w_bit_tick ? '0 : r_bit_cnt + CNT_W'(1);
          if (w_data_shift) begin
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        B_STOP: begin
          r_bit_cnt <= w_bit_tick ? '0 : r_bit_cnt + CNT_W'(1);
        end
        default: begin
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  // Byte-level strobes appear the cycle after the stop sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_byte       <= '0;
      r_rx_byte_valid <= 1'b0;
      r_frame_error   <= 1'b0;
    end else begin
      r_rx_byte_valid <= w_byte_done;
      r_frame_error   <= w_frame_set;
      if (w_byte_done) begin
        r_rx_byte <= r_shift;
      end
    end
  end

  // ------------------------------------------------------------------
  // Packet parser
  // ------------------------------------------------------------------
  pkt_state_t       r_pstate;
  pkt_state_t       w_pstate_next;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [7:0]       r_sh_cmd;
  logic [7:0]       r_sh_lo;
  logic [7:0]       r_sh_hi;
  logic [7:0]       r_cmd_code;
  logic [15:0]      r_cmd_arg;
  logic             r_cmd_valid;
  logic             r_csum_error;
  logic             r_timeout_error;
  logic [7:0]       r_err_count;
  logic             w_timeout;
  logic             w_byte_in;
  logic             w_cmd_set;
  logic             w_csum_set;
  logic             w_err_any;

  // A timeout expiring in the same cycle as a byte arrival discards the byte.
  assign w_timeout = (r_pstate != P_SYNC) && (r_tmo_cnt == TMO_LIMIT);
  assign w_byte_in = r_rx_byte_valid && !w_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pstate <= P_SYNC;
    end else begin
      r_pstate <= w_pstate_next;
    end
  end

  always_comb begin
    w_pstate_next = r_pstate;
    w_cmd_set     = 1'b0;
    w_csum_set    = 1'b0;
    if (w_timeout) begin
      w_pstate_next = P_SYNC;
    end else if (r_frame_error && (r_pstate != P_SYNC)) begin
      w_pstate_next = P_SYNC;
    end else if (w_byte_in) begin
      case (r_pstate)
        P_SYNC: begin
          if (r_rx_byte == SYNC_BYTE) begin
            w_pstate_next = P_CMD;
          end
        end
        P_CMD:    w_pstate_next = P_ARG_LO;
        P_ARG_LO: w_pstate_next = P_ARG_HI;
        P_ARG_HI: w_pstate_next = P_CSUM;
        P_CSUM: begin
          w_pstate_next = P_SYNC;
          if (r_rx_byte == (r_sh_cmd ^ r_sh_lo ^ r_sh_hi)) begin
            w_cmd_set = 1'b1;
          end else begin
            w_csum_set = 1'b1;
          end
        end
        default: w_pstate_next = P_SYNC;
      endcase
    end
  end

  // Inter-byte timeout: only runs while a packet is partially received.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_pstate == P_SYNC) || r_rx_byte_valid || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Shadow registers; the argument arrives little-endian.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_cmd <= '0;
      r_sh_lo  <= '0;
      r_sh_hi  <= '0;
    end else if (w_byte_in) begin
      case (r_pstate)
        P_CMD:    r_sh_cmd <= r_rx_byte;
        P_ARG_LO: r_sh_lo  <= r_rx_byte;
        P_ARG_HI: r_sh_hi  <= r_rx_byte;
        default: begin
        end
      endcase
    end
  end

  // Command outputs and parser error strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_valid     <= 1'b0;
      r_csum_error    <= 1'b0;
      r_timeout_error <= 1'b0;
      r_cmd_code      <= '0;
      r_cmd_arg       <= '0;
    end else begin
      r_cmd_valid     <= w_cmd_set;
      r_csum_error    <= w_csum_set;
      r_timeout_error <= w_timeout;
      if (w_cmd_set) begin
        r_cmd_code <= r_sh_cmd;
        r_cmd_arg  <= {r_sh_hi, r_sh_lo};
      end
    end
  end

  // Error tally updates on the same edge that raises the strobes, so the
  // new count is visible alongside them. Coincident errors count once.
  assign w_err_any = w_frame_set | w_csum_set | w_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_count <= '0;
    end else if (w_err_any && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign o_rx_byte       = r_rx_byte;
  assign o_rx_byte_valid = r_rx_byte_valid;
  assign o_frame_error   = r_frame_error;
  assign o_cmd_valid     = r_cmd_valid;
  assign o_cmd_code      = r_cmd_code;
  assign o_cmd_arg       = r_cmd_arg;
  assign o_csum_error    = r_csum_error;
  assign o_timeout_error = r_timeout_error;
  assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx
//
// Self-checking bench for uart_cmd_rx. Stimulus tasks drive UART frames and
// feed a packet-level reference model, which pushes the expected DUT events
// into a queue. A monitor pops and compares each event when the DUT strobes.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;

  localparam int DF = 16;
  localparam int FT = 2000;

  localparam int K_BYTE  = 0;
  localparam int K_CMD   = 1;
  localparam int K_CSUM  = 2;
  localparam int K_FRAME = 3;
  localparam int K_TMO   = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        rxLine = 1'b1;
  logic [7:0]  rxByte;
  logic        rxByteValid;
  logic        cmdValid;
  logic [7:0]  cmdCode;
  logic [15:0] cmdArg;
  logic        frameError;
  logic        csumError;
  logic        timeoutError;
  logic [7:0]  errCount;

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .DELAY_FRAMES (DF),
    .FRAME_TIMEOUT(FT)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_uart_rx      (rxLine),
    .o_rx_byte      (rxByte),
    .o_rx_byte_valid(rxByteValid),
    .o_cmd_valid    (cmdValid),
    .o_cmd_code     (cmdCode),
    .o_cmd_arg      (cmdArg),
    .o_frame_error  (frameError),
    .o_csum_error   (csumError),
    .o_timeout_error(timeoutError),
    .o_err_count    (errCount)
  );

  typedef struct {
    int          kind;
    logic [7:0]  b;
    logic [7:0]  code;
    logic [15:0] arg;
    logic [7:0]  errc;
  } evt_t;

  evt_t        expQ[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: packet bytes collected since the last sync byte.
  logic [7:0]  pkt[$];
  logic [7:0]  modelCode = 8'h00;
  logic [15:0] modelArg = 16'h0000;
  int          modelErr = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void pushEvt(input int kind, input logic [7:0] b);
    evt_t e;
    e.kind = kind;
    e.b    = b;
    e.code = modelCode;
    e.arg  = modelArg;
    e.errc = 8'(modelErr);
    expQ.push_back(e);
  endfunction

  function automatic void countError();
    if (modelErr < 255) modelErr++;
  endfunction

  // Packet rules: hunt for 0xA5, collect five bytes, accept when the
  // checksum equals cmd ^ lo ^ hi; a framing error drops the partial packet.
  function automatic void modelByte(input logic [7:0] b, input bit stopGood);
    if (!stopGood) begin
      countError();
      pushEvt(K_FRAME, 8'h00);
      pkt.delete();
      return;
    end
    pushEvt(K_BYTE, b);
    if (pkt.size() == 0 && b != 8'hA5) return;
    pkt.push_back(b);
    if (pkt.size() == 5) begin
      if ((pkt[1] ^ pkt[2] ^ pkt[3]) == pkt[4]) begin
        modelCode = pkt[1];
        modelArg  = {pkt[3], pkt[2]};
        pushEvt(K_CMD, 8'h00);
      end else begin
        countError();
        pushEvt(K_CSUM, 8'h00);
      end
      pkt.delete();
    end
  endfunction

  task automatic idleCycles(input int n);
    if (n >= FT && pkt.size() != 0) begin
      countError();
      pushEvt(K_TMO, 8'h00);
      pkt.delete();
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stopGood, input int gap);
    modelByte(b, stopGood);
    @(negedge clk);
    rxLine = 1'b0;
    repeat (DF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxLine = b[i];
      repeat (DF) @(negedge clk);
    end
    rxLine = stopGood;
    repeat (DF) @(negedge clk);
    rxLine = 1'b1;
    idleCycles(gap);
  endtask

  task automatic sendPacket(input logic [7:0] c, input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] cs, input int gap);
    applyStimulus(8'hA5, 1'b1, gap);
    applyStimulus(c, 1'b1, gap);
    applyStimulus(lo, 1'b1, gap);
    applyStimulus(hi, 1'b1, gap);
    applyStimulus(cs, 1'b1, gap);
  endtask

  task automatic sendGood(input logic [7:0] c, input logic [15:0] arg);
    sendPacket(c, arg[7:0], arg[15:8], c ^ arg[7:0] ^ arg[15:8], 0);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput({name, "_drain"}, expQ.size(), 0);
    checkOutput({name, "_err_count"}, errCount, modelErr);
    checkOutput({name, "_cmd_code"}, cmdCode, modelCode);
    checkOutput({name, "_cmd_arg"}, cmdArg, modelArg);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_rx_byte"}, rxByte, 0);
    checkOutput({name, "_strobes"},
                {rxByteValid, cmdValid, frameError, csumError, timeoutError}, 0);
    checkOutput({name, "_cmd"}, {cmdCode, cmdArg}, 0);
    checkOutput({name, "_err_count"}, errCount, 0);
  endtask

  task automatic popExpect(input int kind, output evt_t e);
    e.kind = -1;
    e.b    = 8'h00;
    e.code = 8'h00;
    e.arg  = 16'h0000;
    e.errc = 8'h00;
    checkOutput("event_expected", expQ.size() != 0, 1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("event_kind", e.kind, kind);
    end
  endtask

  // Monitor: each DUT strobe consumes one expected event, in a fixed order.
  logic prevByteValid = 1'b0;
  always @(negedge clk) begin
    evt_t e;
    if (rstN) begin
      if (rxByteValid) begin
        popExpect(K_BYTE, e);
        checkOutput("rx_byte", rxByte, e.b);
      end
      if (frameError) begin
        popExpect(K_FRAME, e);
        checkOutput("frame_err_count", errCount, e.errc);
      end
      if (cmdValid) begin
        popExpect(K_CMD, e);
        checkOutput("cmd_code", cmdCode, e.code);
        checkOutput("cmd_arg", cmdArg, e.arg);
        checkOutput("cmd_latency", prevByteValid, 1);
        checkOutput("cmd_err_count", errCount, e.errc);
      end
      if (csumError) begin
        popExpect(K_CSUM, e);
        checkOutput("csum_held_code", cmdCode, e.code);
        checkOutput("csum_held_arg", cmdArg, e.arg);
        checkOutput("csum_err_count", errCount, e.errc);
      end
      if (timeoutError) begin
        popExpect(K_TMO, e);
        checkOutput("tmo_err_count", errCount, e.errc);
      end
    end
    prevByteValid = rxByteValid;
  end

  initial begin
    #1_200_000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int need;
    int choice;
    logic [7:0] c, lo, hi, cs;

    // Reset state
    repeat (5) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    // Valid packet
    sendPacket(8'h01, 8'h34, 8'h12, 8'h27, 0);
    waitDrain("t1");

    // Checksum error
    sendPacket(8'h01, 8'h34, 8'h12, 8'h28, 0);
    waitDrain("t2");

    // Short low glitch is a false start
    @(negedge clk);
    rxLine = 1'b0;
    repeat (4) @(negedge clk);
    rxLine = 1'b1;
    idleCycles(100);
    sendGood(8'h10, 16'hABCD);
    waitDrain("t3");

    // Framing error mid-packet, then resync
    applyStimulus(8'hA5, 1'b1, 0);
    applyStimulus(8'h02, 1'b1, 0);
    applyStimulus(8'h00, 1'b0, 2);
    sendPacket(8'h03, 8'h00, 8'h01, 8'h02, 0);
    waitDrain("t4");

    // Garbage, partial packet, timeout, recovery
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    applyStimulus(8'hA5, 1'b1, 0);
    applyStimulus(8'h07, 1'b1, 0);
    idleCycles(FT);
    sendGood(8'h05, 16'h8001);
    waitDrain("t5");

    // Randomised traffic
    for (int it = 0; it < 8; it++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--)
        applyStimulus(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 30));
      c  = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 255));
      cs = c ^ lo ^ hi;
      choice = $urandom_range(0, 9);
      if (choice < 3) cs = cs ^ 8'($urandom_range(1, 255));
      applyStimulus(8'hA5, 1'b1, $urandom_range(0, 30));
      applyStimulus(c, 1'b1, $urandom_range(0, 30));
      if (choice == 9) applyStimulus(8'($urandom_range(0, 255)), 1'b0, 2);
      applyStimulus(lo, 1'b1, $urandom_range(0, 30));
      applyStimulus(hi, 1'b1, $urandom_range(0, 30));
      applyStimulus(cs, 1'b1, $urandom_range(0, 30));
    end
    idleCycles(FT + 100);
    waitDrain("rand");

    // Error counter saturation
    for (int k = 0; k < 6; k++) sendPacket(8'h11, 8'h22, 8'h33, 8'h00, 0);
    need = 260 - modelErr;
    for (int k = 0; k < need; k++) applyStimulus(8'h00, 1'b0, 2);
    waitDrain("sat");
    checkOutput("err_saturated", errCount, 255);

    // Reset in the middle of a byte
    @(negedge clk);
    rxLine = 1'b0;
    repeat (2 * DF + 3) @(negedge clk);
    rstN = 1'b0;
    rxLine = 1'b1;
    modelErr = 0;
    modelCode = 8'h00;
    modelArg = 16'h0000;
    pkt.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkAllZero("midreset");
    end
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    idleCycles(3 * DF);
    sendGood(8'h42, 16'h5A3C);
    waitDrain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
